// File: rtl/sseg_codes_pkg.sv
// Shared codes, state encoding and range limits for the
// seven-segment result formatter.
package sseg_codes_pkg;

  localparam logic [4:0] CODE_BLANK = 5'd16;
  localparam logic [4:0] CODE_MINUS = 5'd17;
  localparam logic [4:0] CODE_E     = 5'd18;
  localparam logic [4:0] CODE_R     = 5'd19;

  localparam logic [31:0] POS_MAX = 32'd9999;
  localparam logic [31:0] NEG_MAX = 32'd999;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FORMAT = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble correction cell: add 3 to a BCD nibble
// that is 5 or more, ahead of the left shift.
module bcd_adj3 (
  input  logic [3:0] d,
  output logic [3:0] q
);

  always_comb begin
    q = d;
    if (d >= 4'd5) q = d + 4'd3;
  end

endmodule

// File: rtl/sseg_formatter.sv
// Signed result to four display codes: sequential double-dabble,
// leading-zero blanking, minus placement and "Err" overflow.
module sseg_formatter
  import sseg_codes_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int BCD_DIGITS = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  input  logic [3:0]       dp_sel,
  output logic             busy,
  output logic             done,
  output logic [4:0]       leftmost,
  output logic [4:0]       left_center,
  output logic [4:0]       right_center,
  output logic [4:0]       rightmost,
  output logic             leftmost_dp,
  output logic             left_center_dp,
  output logic             right_center_dp,
  output logic             rightmost_dp
);

  localparam int BW = 4 * BCD_DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic             neg_q, neg_d;
  logic             err_q, err_d;
  logic [3:0]       dpsel_q, dpsel_d;
  logic [3:0][4:0]  code_q, code_d;
  logic [3:0]       dp_q, dp_d;
  logic             done_q, done_d;

  logic [BW-1:0]    bcd_adj;
  logic [WIDTH-1:0] mag_in;
  logic             err_in;
  logic [3:0][4:0]  fmt;

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    bcd_adj3 u_adj (
      .d (bcd_q[4*g +: 4]),
      .q (bcd_adj[4*g +: 4])
    );
  end

  // -2^(W-1) wraps to itself, which reads correctly as unsigned
  assign mag_in = value[WIDTH-1] ? (~value) + WIDTH'(1) : value;
  assign err_in = value[WIDTH-1] ? (32'(mag_in) > NEG_MAX)
                                 : (32'(mag_in) > POS_MAX);

  logic [3:0] d3, d2, d1, d0;
  logic       s3, s2, s1;
  logic       ovf;

  assign d3  = bcd_q[15:12];
  assign d2  = bcd_q[11:8];
  assign d1  = bcd_q[7:4];
  assign d0  = bcd_q[3:0];
  assign s3  = (d3 != 4'd0);
  assign s2  = s3 | (d2 != 4'd0);
  assign s1  = s2 | (d1 != 4'd0);
  assign ovf = err_q | (|bcd_q[BW-1:16]);

  // sN: digit N or something left of it is nonzero
  always_comb begin
    fmt[3] = s3 ? {1'b0, d3} : CODE_BLANK;
    fmt[2] = s2 ? {1'b0, d2} : CODE_BLANK;
    fmt[1] = s1 ? {1'b0, d1} : CODE_BLANK;
    fmt[0] = {1'b0, d0};
    if (neg_q) begin
      unique case (1'b1)
        (s2 && !s3): fmt[3] = CODE_MINUS;
        (s1 && !s2): fmt[2] = CODE_MINUS;
        (!s1):       fmt[1] = CODE_MINUS;
        default: ;
      endcase
    end
    if (ovf) fmt = {CODE_E, CODE_R, CODE_R, CODE_BLANK};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    err_d   = err_q;
    dpsel_d = dpsel_q;
    code_d  = code_q;
    dp_d    = dp_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          neg_d   = value[WIDTH-1];
          mag_d   = mag_in;
          err_d   = err_in;
          dpsel_d = dp_sel;
          bcd_d   = '0;
          cnt_d   = CW'(WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = {bcd_adj[BW-2:0], mag_q[WIDTH-1]};
        mag_d = {mag_q[WIDTH-2:0], 1'b0};
        // a carry out of the top digit can only mean overflow
        err_d = err_q | bcd_adj[BW-1];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FORMAT;
      end
      FORMAT: begin
        code_d  = fmt;
        dp_d    = dpsel_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mag_q   <= '0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
      dpsel_q <= '0;
      code_q  <= {4{CODE_BLANK}};
      dp_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
      dpsel_q <= dpsel_d;
      code_q  <= code_d;
      dp_q    <= dp_d;
      done_q  <= done_d;
    end
  end

  assign busy            = (state_q != IDLE);
  assign done            = done_q;
  assign leftmost        = code_q[3];
  assign left_center     = code_q[2];
  assign right_center    = code_q[1];
  assign rightmost       = code_q[0];
  assign leftmost_dp     = dp_q[3];
  assign left_center_dp  = dp_q[2];
  assign right_center_dp = dp_q[1];
  assign rightmost_dp    = dp_q[0];

endmodule

// File: tb/tb_sseg_formatter.sv
// Directed bench for sseg_formatter: reset, latency,
// formatting cases, ignored start and held start.
module tb_sseg_formatter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] value;
  logic [3:0]  dp_sel;
  logic        busy, done;
  logic [4:0]  leftmost, left_center, right_center, rightmost;
  logic        leftmost_dp, left_center_dp;
  logic        right_center_dp, rightmost_dp;

  logic [19:0] codes;
  logic [3:0]  dps;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sseg_formatter #(.WIDTH(16), .BCD_DIGITS(5)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .value           (value),
    .dp_sel          (dp_sel),
    .busy            (busy),
    .done            (done),
    .leftmost        (leftmost),
    .left_center     (left_center),
    .right_center    (right_center),
    .rightmost       (rightmost),
    .leftmost_dp     (leftmost_dp),
    .left_center_dp  (left_center_dp),
    .right_center_dp (right_center_dp),
    .rightmost_dp    (rightmost_dp)
  );

  assign codes = {leftmost, left_center, right_center, rightmost};
  assign dps   = {leftmost_dp, left_center_dp,
                  right_center_dp, rightmost_dp};

  // start sampled at edge N; lat = edges after N until done
  task automatic run(input logic [15:0] v, input logic [3:0] dp,
                     output int lat, output int bcnt);
    @(posedge clk); #1;
    value = v; dp_sel = dp; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset();
    int dcnt;
    rst = 1'b1; start = 1'b0; value = '0; dp_sel = '0;
    #12;
    checks++;
    if (codes !== {4{5'd16}}) begin
      errors++;
      $display("FAIL reset_codes got=%h want=%h", codes, {4{5'd16}});
    end
    checks++;
    if (dps !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags dp=%b busy=%b done=%b want 0000/0/0",
               dps, busy, done);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    value = 16'd1234; dp_sel = 4'b1111; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || codes !== {4{5'd16}} || dps !== 4'b0000) begin
      errors++;
      $display("FAIL reset_midshift busy=%b codes=%h dp=%b want 0/%h/0000",
               busy, codes, {4{5'd16}}, dps);
    end
    #2 rst = 1'b0;
    dcnt = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    checks++;
    if (dcnt != 0 || codes !== {4{5'd16}}) begin
      errors++;
      $display("FAIL reset_nodone dones=%0d codes=%h want 0/%h",
               dcnt, codes, {4{5'd16}});
    end
  endtask

  task automatic test_basic();
    int lat, bcnt;
    run(16'd1234, 4'b0100, lat, bcnt);
    checks++;
    if (lat != 17) begin
      errors++;
      $display("FAIL basic_latency got=%0d want=17", lat);
    end
    checks++;
    if (bcnt != 17) begin
      errors++;
      $display("FAIL basic_busy got=%0d want=17", bcnt);
    end
    checks++;
    if (codes !== {5'd1, 5'd2, 5'd3, 5'd4}) begin
      errors++;
      $display("FAIL basic_codes got=%h want=%h", codes,
               {5'd1, 5'd2, 5'd3, 5'd4});
    end
    checks++;
    if (dps !== 4'b0100) begin
      errors++;
      $display("FAIL basic_dp got=%b want=0100", dps);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || codes !== {5'd1, 5'd2, 5'd3, 5'd4}) begin
      errors++;
      $display("FAIL basic_pulse done=%b codes=%h want 0 and held",
               done, codes);
    end
  endtask

  task automatic test_format();
    logic [15:0] vals [9];
    logic [19:0] exps [9];
    logic [3:0]  dpv;
    int lat, bcnt;
    vals[0] = 16'd0;     exps[0] = {5'd16, 5'd16, 5'd16, 5'd0};
    vals[1] = -16'sd5;   exps[1] = {5'd16, 5'd16, 5'd17, 5'd5};
    vals[2] = -16'sd999; exps[2] = {5'd17, 5'd9, 5'd9, 5'd9};
    vals[3] = 16'd10000; exps[3] = {5'd18, 5'd19, 5'd19, 5'd16};
    vals[4] = -16'sd1000; exps[4] = {5'd18, 5'd19, 5'd19, 5'd16};
    vals[5] = 16'h8000;  exps[5] = {5'd18, 5'd19, 5'd19, 5'd16};
    vals[6] = 16'd9999;  exps[6] = {5'd9, 5'd9, 5'd9, 5'd9};
    vals[7] = -16'sd80;  exps[7] = {5'd16, 5'd17, 5'd8, 5'd0};
    vals[8] = 16'd100;   exps[8] = {5'd16, 5'd1, 5'd0, 5'd0};
    for (int k = 0; k < 9; k++) begin
      dpv = 4'(k) ^ 4'b1010;
      run(vals[k], dpv, lat, bcnt);
      checks++;
      if (lat != 17 || codes !== exps[k] || dps !== dpv) begin
        errors++;
        $display("FAIL fmt_%0d val=%h lat=%0d codes=%h dp=%b want 17/%h/%b",
                 k, vals[k], lat, codes, dps, exps[k], dpv);
      end
    end
  endtask

  task automatic test_ignore_start();
    int dcnt, dat;
    @(posedge clk); #1;
    value = 16'd42; dp_sel = 4'b0001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dcnt = 0; dat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 4) begin start = 1'b1; value = 16'd999; end
      if (i == 5) start = 1'b0;
      if (done) begin dcnt++; dat = i; end
    end
    checks++;
    if (dcnt != 1 || dat != 17) begin
      errors++;
      $display("FAIL ignore_done count=%0d at=%0d want 1 at 17", dcnt, dat);
    end
    checks++;
    if (codes !== {5'd16, 5'd16, 5'd4, 5'd2} || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_codes got=%h busy=%b want=%h/0", codes, busy,
               {5'd16, 5'd16, 5'd4, 5'd2});
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2, dcnt;
    logic [19:0] c1, c2;
    logic b18;
    @(posedge clk); #1;
    value = 16'd7; dp_sel = 4'b0000; start = 1'b1;
    @(posedge clk); #1;
    d1 = 0; d2 = 0; dcnt = 0; c1 = '0; c2 = '0; b18 = 1'b0;
    for (int i = 1; i <= 45; i++) begin
      @(posedge clk); #1;
      if (i == 5) value = 16'd8;
      if (i == 18) b18 = busy;
      if (done) begin
        dcnt++;
        if (dcnt == 1) begin d1 = i; c1 = codes; end
        else begin d2 = i; c2 = codes; start = 1'b0; end
      end
    end
    start = 1'b0;
    checks++;
    if (d1 != 17 || c1 !== {5'd16, 5'd16, 5'd16, 5'd7}) begin
      errors++;
      $display("FAIL b2b_first at=%0d codes=%h want 17/%h", d1, c1,
               {5'd16, 5'd16, 5'd16, 5'd7});
    end
    checks++;
    if (b18 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_recapture busy=%b want=1", b18);
    end
    checks++;
    if (dcnt != 2 || d2 != 35 || c2 !== {5'd16, 5'd16, 5'd16, 5'd8}) begin
      errors++;
      $display("FAIL b2b_second count=%0d at=%0d codes=%h want 2/35/%h",
               dcnt, d2, c2, {5'd16, 5'd16, 5'd16, 5'd8});
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle busy=%b want=0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_format();
    test_ignore_start();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
